// File: rtl/fisc_dispatch_pkg.sv
// Types, default sizes and opcode extraction for the microcode dispatch block.
`ifndef R_FMT_OPCODE_SZ
`define R_FMT_OPCODE_SZ 11
`endif

package fisc_dispatch_pkg;

   localparam int unsigned INSTR_W_DEF  = 32;
   localparam int unsigned OPCODE_W_DEF = `R_FMT_OPCODE_SZ;
   localparam int unsigned OPC_MSB_DEF  = 31;
   localparam int unsigned SEQ_LAT_DEF  = 2;
   localparam int unsigned TIMEOUT_DEF  = 255;
   localparam int unsigned CNT_W_DEF    = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      LATENCY   = 3'd2,
      WAIT_LAST = 3'd3,
      WAIT_ACK  = 3'd4,
      WAIT_IDLE = 3'd5
   } state_e;

   // R-format opcode: OPCODE_W_DEF bits ending at bit msb of the instruction.
   function automatic logic [OPCODE_W_DEF-1:0] extract_opcode(input logic [63:0] instr,
                                                              input int unsigned msb);
      return OPCODE_W_DEF'(instr >> (msb + 1 - OPCODE_W_DEF));
   endfunction

endpackage

// File: rtl/microcode_dispatch_if.sv
// Fetch-side valid/ready channel plus the sequencer segment handshake.
interface microcode_dispatch_if #(
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned OPCODE_W = 11
) ();
   logic                instr_valid;
   logic                instr_ready;
   logic [INSTR_W-1:0]  instr;
   logic                flush;
   logic                sos;
   logic [OPCODE_W-1:0] microcode_opcode;
   logic                eos;

   // Dispatcher side.
   modport master (
      input  instr_valid, instr, flush, eos,
      output instr_ready, sos, microcode_opcode
   );

   // Fetch / sequencer side.
   modport slave (
      output instr_valid, instr, flush, eos,
      input  instr_ready, sos, microcode_opcode
   );
endinterface

// File: rtl/dispatch_inbuf.sv
// One-entry valid/ready instruction buffer with flush.
module dispatch_inbuf #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   input  logic         i_flush,
   input  logic         i_drain,
   output logic         o_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data
);
   logic         r_valid;
   logic [W-1:0] r_data;

   // Ready only while empty, so a fill and a drain never meet in one cycle.
   assign o_ready = rst_n && !r_valid;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Flush or drain empties the entry; otherwise an accepted transfer fills it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush || i_drain) begin
         r_valid <= 1'b0;
      end else if (i_valid && o_ready) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end
endmodule

// File: rtl/fisc_defines.sv
// Shared FISC instruction-format widths.
`ifndef R_FMT_OPCODE_SZ
`define R_FMT_OPCODE_SZ 11
`endif

// File: rtl/microcode_dispatch.sv
// Issues buffered instructions to the microcode sequencer and tracks each segment
// through last word, done-acknowledge and return to idle.
module microcode_dispatch
   import fisc_dispatch_pkg::*;
#(
   parameter int unsigned INSTR_W  = INSTR_W_DEF,
   parameter int unsigned OPCODE_W = OPCODE_W_DEF,
   parameter int unsigned OPC_MSB  = OPC_MSB_DEF,
   parameter int unsigned SEQ_LAT  = SEQ_LAT_DEF,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   microcode_dispatch_if.master bus,
   output logic                 busy,
   output logic                 retire,
   output logic [CNT_W-1:0]     retire_count,
   output logic                 timeout_err
);
   localparam int unsigned LAT_W = $clog2(SEQ_LAT + 2);
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

   state_e              r_state, w_state;
   logic [LAT_W-1:0]    r_lat, w_lat;
   logic [WD_W-1:0]     r_wd, w_wd;
   logic                r_sos, w_sos;
   logic [OPCODE_W-1:0] r_opc, w_opc;
   logic                r_busy, w_busy;
   logic                r_retire, w_retire;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic                r_err, w_err;
   logic                w_drain;
   logic                w_wait;
   logic                w_buf_valid;
   logic [INSTR_W-1:0]  w_buf_data;

   dispatch_inbuf #(.W(INSTR_W)) u_inbuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (bus.instr_valid),
      .i_data  (bus.instr),
      .i_flush (bus.flush),
      .i_drain (w_drain),
      .o_ready (bus.instr_ready),
      .o_valid (w_buf_valid),
      .o_data  (w_buf_data)
   );

   assign bus.sos              = r_sos;
   assign bus.microcode_opcode = r_opc;
   assign busy                 = r_busy;
   assign retire               = r_retire;
   assign retire_count         = r_cnt;
   assign timeout_err          = r_err;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_lat    <= '0;
         r_wd     <= '0;
         r_sos    <= 1'b0;
         r_opc    <= '0;
         r_busy   <= 1'b0;
         r_retire <= 1'b0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_lat    <= w_lat;
         r_wd     <= w_wd;
         r_sos    <= w_sos;
         r_opc    <= w_opc;
         r_busy   <= w_busy;
         r_retire <= w_retire;
         r_cnt    <= w_cnt;
         r_err    <= w_err;
      end
   end

   // Segment sequencing, watchdog and next values of the registered outputs.
   always_comb begin
      w_state  = r_state;
      w_lat    = r_lat;
      w_wd     = r_wd;
      w_sos    = 1'b0;
      w_opc    = r_opc;
      w_retire = 1'b0;
      w_cnt    = r_cnt;
      w_err    = r_err;
      w_drain  = 1'b0;
      w_wait   = 1'b0;

      case (r_state)
         IDLE: begin
            // A same-cycle flush beats the issue.
            if (w_buf_valid && !bus.flush) begin
               w_state = ISSUE;
               w_sos   = 1'b1;
               w_opc   = OPCODE_W'(extract_opcode(64'(w_buf_data), OPC_MSB));
               w_drain = 1'b1;
               w_lat   = LAT_W'(SEQ_LAT);
            end
         end
         ISSUE: w_state = LATENCY;
         LATENCY: begin
            // eos is stale while the sequencer reads its ROM and loads the first word.
            if (r_lat != '0) w_lat = r_lat - LAT_W'(1);
            if (r_lat <= LAT_W'(1)) w_state = WAIT_LAST;
         end
         WAIT_LAST: begin
            w_wait = 1'b1;
            if (bus.eos) w_state = WAIT_ACK;
         end
         WAIT_ACK: begin
            w_wait = 1'b1;
            if (!bus.eos) w_state = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            w_wait = 1'b1;
            if (bus.eos) begin
               w_state  = IDLE;
               w_retire = 1'b1;
               w_cnt    = r_cnt + CNT_W'(1);
            end
         end
         default: w_state = IDLE;
      endcase

      // Watchdog restarts on any state change and aborts a stalled wait.
      if (w_state != r_state) begin
         w_wd = '0;
      end else if (w_wait) begin
         if (r_wd == WD_W'(TIMEOUT - 1)) begin
            w_state = IDLE;
            w_err   = 1'b1;
            w_wd    = '0;
         end else begin
            w_wd = r_wd + WD_W'(1);
         end
      end

      w_busy = (w_state != IDLE);
   end
endmodule

// File: doc/microcode_dispatch.md
Name: microcode_dispatch

Overview:
- Datapath-side initiator of the microcode segment handshake.
- Accepts fetched instructions over a valid/ready interface and buffers one of them.
- Extracts the R-format opcode, pulses sos with the opcode held stable, then tracks the sequencer's eos bit through last word, done-acknowledge and return to idle before issuing the next segment.
- Sits between fetch/decode and the microcode sequencer; provides retire pulses, a retire counter and a hang watchdog.

Parameters:
- INSTR_W, 32: instruction width.
- OPCODE_W, 11: opcode width; equals `R_FMT_OPCODE_SZ.
- OPC_MSB, 31: MSB of the opcode field; opcode = instr[OPC_MSB -: OPCODE_W].
- SEQ_LAT, 2: cycles after the sos cycle during which eos is ignored (sequencer ROM wait plus DECODING1 load).
- TIMEOUT, 255: maximum cycles spent in any wait state before an error is raised.
- CNT_W, 16: retire counter width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low; clock clk.
- instr_valid, in, 1: fetch has an instruction.
- instr_ready, out, 1: buffer can accept an instruction.
- instr, in, INSTR_W: instruction word.
- flush, in, 1: discard the buffered, not yet issued, instruction.
- sos, out, 1: start-of-segment pulse to the sequencer.
- microcode_opcode, out, OPCODE_W: opcode to the sequencer; stable from the sos cycle until retire.
- eos, in, 1: microcode_ctrl[0] from the sequencer.
- busy, out, 1: a segment is in flight (any state other than IDLE).
- retire, out, 1: one-cycle pulse when a segment completes.
- retire_count, out, CNT_W: number of completed segments.
- timeout_err, out, 1: sticky watchdog error.

Behaviour:
- Reset values: sos=0, microcode_opcode=0, instr_ready=0, busy=0, retire=0, retire_count=0, timeout_err=0, buffer empty, state IDLE, watchdog=0.
- Reset applies mid-operation: any in-flight segment is abandoned and the buffered instruction is dropped.
- Buffer:
  - One entry. instr_ready = rst_n && !buf_valid.
  - A transfer happens on a cycle with instr_valid && instr_ready and fills the buffer.
  - Filling and draining in the same cycle is impossible because ready is low whenever the buffer is full.
- flush:
  - Clears buf_valid next cycle.
  - Has no effect on an in-flight segment.
  - A flush in the same cycle as an issue from IDLE wins: no sos is asserted and the buffer is cleared.
- State machine, all registered:
  - IDLE: if buf_valid && !flush, latch opcode into microcode_opcode, assert sos (registered, visible the next cycle), clear buffer, load lat_cnt=SEQ_LAT, go to ISSUE.
  - ISSUE: sos=1 for exactly this one cycle; go to LATENCY.
  - LATENCY: decrement lat_cnt, ignore eos; at 0 go to WAIT_LAST.
  - WAIT_LAST: eos==1 (final microword loaded) goes to WAIT_ACK. This covers single-word segments, whose eos is 1 on the first sampled word.
  - WAIT_ACK: eos==0 (sequencer DONE acknowledge) goes to WAIT_IDLE.
  - WAIT_IDLE: eos==1 (sequencer back in WAITING); pulse retire the next cycle, increment retire_count (wraps modulo 2^CNT_W), go to IDLE.
- Issue spacing: a new sos is never asserted before the sequencer reports idle. Minimum sos-to-sos spacing is 7 cycles for a single-word segment.
- Watchdog:
  - Cleared on every state change.
  - Counts in WAIT_LAST, WAIT_ACK and WAIT_IDLE.
  - On reaching TIMEOUT: set timeout_err (sticky until reset), force the state to IDLE, no retire, count unchanged.
- microcode_opcode holds its last value while in IDLE.

Decomposition:
- fisc_dispatch_pkg: state enum (IDLE, ISSUE, LATENCY, WAIT_LAST, WAIT_ACK, WAIT_IDLE) and an opcode-extraction function.
- Opcode width comes from `R_FMT_OPCODE_SZ in fisc_defines.sv.
- Sub-module dispatch_inbuf: one-entry valid/ready buffer with flush.

Test Plan:
- Reset release, instr=32'hD280_0000 valid: ready high first cycle after reset -> sos pulses once with opcode 11'h694, held until retire.
- Single-word segment model (eos 1,1,1,0,1): exactly one retire; retire_count 0->1; busy low after 7 cycles.
- Three-word segment (eos 0,0,1,0,1 after latency): no early retire on the first low eos; retire only after the final high.
- Back-to-back valid instructions A, B: B buffered with ready low; B's sos asserted only after A retires; count=2.
- Flush asserted the same cycle B would issue -> no sos for B; ready high next cycle.
- eos stuck at 0 with TIMEOUT=8 -> timeout_err=1, state IDLE, retire_count unchanged; then rst_n=0 mid-segment clears all outputs.
